display_mode_ctrl: RTL

//   Sequencer for the 4-digit time/date display mux. Drives the mux `select`

---
 rtl/display_mode_if.sv | 33 +++
 rtl/display_mode_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/display_mode_if.sv
// Signal bundle between the display mode sequencer and its surroundings.
//   tick       1 Hz strobe, one clk cycle wide (into the sequencer)
//   btn        raw mode button, asynchronous, active-high (into the sequencer)
//   select     display mux select, 1 = time view, 0 = date view (from the sequencer)
//   auto_mode  1 = automatic time/date alternation enabled (from the sequencer)
//   dwell      ticks elapsed in the current view (from the sequencer)
// The "slave" modport is the sequencer side; "master" is the side that
// produces tick/btn and consumes the display controls.
interface display_mode_if #(
    parameter int CNT_W = 4
);
    logic             tick;
    logic             btn;
    logic             select;
    logic             auto_mode;
    logic [CNT_W-1:0] dwell;

    modport master (
        output tick,
        output btn,
        input  select,
        input  auto_mode,
        input  dwell
    );

    modport slave (
        input  tick,
        input  btn,
        output select,
        output auto_mode,
        output dwell
    );
endinterface

// File: rtl/display_mode_ctrl.sv
// Sequencer for the 4-digit time/date display mux.
//   clk    system clock
//   n_rst  asynchronous active-low reset
//   bus    display_mode_if slave modport:
//            tick (in)       1 Hz strobe, one clk wide
//            btn (in)        raw mode button, asynchronous, active-high
//            select (out)    1 = hour/min digits, 0 = day/month/year digits
//            auto_mode (out) 1 = time/date alternate automatically on ticks
//            dwell (out)     ticks spent in the current state
// A short press of the button peeks at the date for DATE_SECS ticks; a press
// held for LONG_PRESS ticks toggles auto mode instead.
module display_mode_ctrl #(
    parameter int TIME_SECS  = 8,
    parameter int DATE_SECS  = 3,
    parameter int LONG_PRESS = 2,
    parameter int CNT_W      = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    display_mode_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIME_LAST = CNT_W'(TIME_SECS - 1);
    localparam logic [CNT_W-1:0] DATE_LAST = CNT_W'(DATE_SECS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS - 1);

    typedef enum logic [1:0] {
        S_TIME = 2'd0,
        S_DATE = 2'd1,
        S_PEEK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer and edge detection
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic b_s_reg;
    logic b_q_reg;
    logic press;
    logic rel;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1_reg <= 1'b0;
            b_s_reg   <= 1'b0;
            b_q_reg   <= 1'b0;
        end else begin
            sync1_reg <= bus.btn;
            b_s_reg   <= sync1_reg;
            b_q_reg   <= b_s_reg;
        end
    end

    assign press = b_s_reg & ~b_q_reg;
    assign rel   = ~b_s_reg & b_q_reg;

    // ------------------------------------------------------------------
    // Long / short press classification and auto mode
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] hold_cnt_reg;
    logic             long_done_reg;
    logic             auto_mode_reg;
    logic             long_hit;
    logic             spress;

    // long_done gates the hit so a hold that runs on never toggles twice,
    // even if the hold counter sits saturated at a matching value.
    assign long_hit = bus.tick & b_s_reg & ~press & ~long_done_reg
                      & (hold_cnt_reg == LONG_LAST);
    assign spress   = rel & ~long_done_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hold_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
            auto_mode_reg <= 1'b1;
        end else begin
            if (press) begin
                hold_cnt_reg <= '0;
            end else if (bus.tick && b_s_reg && hold_cnt_reg != CNT_MAX) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end

            if (long_hit) begin
                auto_mode_reg <= ~auto_mode_reg;
                long_done_reg <= 1'b1;
            end else if (rel) begin
                long_done_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // View FSM
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] dwell_reg;
    logic [CNT_W-1:0] dwell_next;
    logic             select_reg;
    logic             select_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= S_TIME;
            dwell_reg  <= '0;
            select_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            dwell_reg  <= dwell_next;
            select_reg <= select_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_TIME: begin
                if (spress) begin
                    state_next = S_PEEK;
                end else if (auto_mode_reg && bus.tick && dwell_reg == TIME_LAST) begin
                    state_next = S_DATE;
                end
            end
            // The date dwell runs to completion even if auto mode is
            // switched off while it is showing.
            S_DATE, S_PEEK: begin
                if (spress) begin
                    state_next = S_TIME;
                end else if (bus.tick && dwell_reg == DATE_LAST) begin
                    state_next = S_TIME;
                end
            end
            default: state_next = S_TIME;
        endcase

        // Any state change restarts the dwell, which also makes a
        // simultaneous spress+tick land on dwell 0.
        dwell_next = dwell_reg;
        if (state_next != state_reg) begin
            dwell_next = '0;
        end else if (bus.tick && dwell_reg != CNT_MAX) begin
            dwell_next = dwell_reg + 1'b1;
        end

        select_next = (state_next == S_TIME);
    end

    assign bus.select    = select_reg;
    assign bus.auto_mode = auto_mode_reg;
    assign bus.dwell     = dwell_reg;

endmodule
